mc14500_icu: RTL and testbench
==============================

Name: mc14500_icu

Overview:
- Parametrised successor to the single-bit MC14500 industrial control unit on the multi-project die.
- Fetches 8-bit instructions from an external asynchronous ROM, one per cycle.
- Over the classic part, adds:
  - a parametrised I/O count, replacing the fixed 8-line bus;
  - an internal absolute JMP target, built from extension words;
  - a hardware return stack of configurable depth;
  - a clock-enable stall input.
- Sits behind the multiplexer, like the other single-clock user designs.

Parameters:
- PC_W, 12: program counter width. (PC_W-4) must be a multiple of 8 and ≥8. EXT_WORDS = (PC_W-4)/8.
- NUM_IN, 8: input bits, 1..16.
- NUM_OUT, 8: output latches, 1..16.
- STACK_DEPTH, 4: return stack entries, ≥1.

Ports:
- clk  in  1  design clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; 0 freezes all state, and pulse outputs read 0.
- pc_o  out  PC_W  fetch address, registered.
- instr_i  in  8  ROM data for pc_o, valid in the same cycle. Bits [3:0] are the opcode; bits [7:4] are imm/IO address.
- in_i  in  NUM_IN  input pins.
- out_o  out  NUM_OUT  output latches.
- rr_o  out  1  result register.
- ien_o, oen_o  out  1  input/output enable registers.
- flag0_o, flagf_o  out  1  one-cycle pulses on NOPO / NOPF.
- jmp_o, rtn_o  out  1  one-cycle pulses when JMP / RTN retires.
- stk_ovf_o, stk_unf_o  out  1  sticky error flags, cleared only by reset.

Behaviour:
- Reset: pc_o, RR, IEN, OEN, out_o, stack pointer, skip flag, error flags and all pulses go to 0. State becomes EXEC.
- Data bit D:
  - D = in_i[imm] & IEN when imm < NUM_IN; otherwise D = 0.
  - IEN and OEN opcodes ignore IEN gating and use the raw in_i[imm] (0 if out of range).
- Opcodes: 0 NOPO, 1 LD, 2 LDC, 3 AND, 4 ANDC, 5 OR, 6 ORC, 7 XNOR, 8 STO, 9 STOC, A IEN, B OEN, C JMP, D RTN, E SKZ, F NOPF.
  - LD: RR=D. LDC: RR=~D.
  - AND/ANDC: RR &= D / RR &= ~D.
  - OR/ORC: RR |= D / RR |= ~D.
  - XNOR: RR = ~(RR^D).
  - STO/STOC write RR / ~RR to out_o[imm], only if OEN=1 and imm < NUM_OUT. Otherwise no write.
- Each non-JMP instruction retires in 1 cycle; PC += 1, wrapping at 2^PC_W.
- SKZ: when RR=0, sets the skip flag. The next instruction is discarded:
  - no state change and no pulses;
  - if the discarded instruction is JMP, PC advances 1+EXT_WORDS in that single cycle.
  - The skip flag then clears.
- JMP, state machine EXEC -> JEXT -> EXEC:
  - EXEC latches imm and sets ext_cnt=0. PC += 1.
  - JEXT: each cycle shifts instr_i into the target register, LSB word first above imm. PC += 1. ext_cnt increments.
  - After EXT_WORDS words:
    - push PC (the address after the last extension word);
    - load PC = {ext words, imm};
    - pulse jmp_o;
    - return to EXEC.
  - Total latency: 1+EXT_WORDS cycles.
- Stack full on JMP: the oldest entry is overwritten (circular) and stk_ovf_o is set. The jump still happens.
- RTN with a non-empty stack: pop into PC, set the skip flag (classic RTN skip), pulse rtn_o.
- RTN with an empty stack: behaves as NOPO without the flag0 pulse, PC += 1, sets stk_unf_o.
- ce=0 mid-JEXT: holds ext_cnt and the partial target; resumes when ce returns to 1.
- Reset asserted mid-operation: aborts immediately, no push occurs.
- PC wrap during JEXT: the extension fetch address wraps to 0 and is legal.

Decomposition:
- Package mc14500_pkg holds:
  - opcode localparams OP_NOPO..OP_NOPF;
  - state enum {ST_EXEC, ST_JEXT};
  - the function computing EXT_WORDS.
- One sub-module, mc14500_stack: a circular LIFO with push/pop, full/empty, and overflow overwrite. Parameters: WIDTH=PC_W, DEPTH=STACK_DEPTH.

Test Plan:
- Logic sequence (all from reset, PC_W=12):
  - Stimulus: in_i=8'hA5. Program ORC 0; IEN 0; OEN 0; LD 2; AND 0; STO 3; LDC 1; STO 4.
  - Response: out_o=8'h18. rr_o=1. Only bits 3 and 4 written.
- OEN gating:
  - Stimulus: OEN driven from in_i[1]=0, then STO 5.
  - Response: out_o unchanged at 0.
- JMP/RTN:
  - Stimulus: JMP at 0x010, imm=4, ext=0x23. RTN at 0x234.
  - Response: jmp_o pulses 2 cycles after fetching 0x010, next pc_o=0x234. After RTN, pc_o=0x012, that instruction is skipped, execution resumes at 0x013.
- SKZ over JMP:
  - Stimulus: RR=0, SKZ at 0x020, JMP at 0x021.
  - Response: pc_o goes 0x021 -> 0x023. jmp_o stays 0. Stack unchanged.
- Stack boundaries (STACK_DEPTH=4):
  - Stimulus: five nested JMPs.
  - Response: stk_ovf_o=1. Five RTNs return to the 5th, 4th, 3rd and 2nd return addresses, then revisit the 5th (circular overwrite).
  - Stimulus: RTN on a freshly reset core.
  - Response: stk_unf_o=1, PC += 1.
- Stall and reset:
  - Stimulus: ce=0 for 3 cycles inside JEXT.
  - Response: pc_o held, the jump lands correctly afterwards.
  - Stimulus: rst_n low during JEXT.
  - Response: pc_o=0 immediately (asynchronous), stack empty.

Source files
------------

// File: rtl/mc14500_pkg.sv
// mc14500_pkg: opcodes, sequencer states and sizing helpers for the mc14500_icu core
package mc14500_pkg;
  localparam logic [3:0] OP_NOPO = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_LDC  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_ANDC = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_ORC  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_STO  = 4'h8;
  localparam logic [3:0] OP_STOC = 4'h9;
  localparam logic [3:0] OP_IEN  = 4'hA;
  localparam logic [3:0] OP_OEN  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_NOPF = 4'hF;

  typedef enum logic {ST_EXEC, ST_JEXT} state_t;

  function automatic int ext_words(input int pc_w);
    return (pc_w - 4) / 8;
  endfunction
endpackage

// File: rtl/mc14500_stack.sv
// mc14500_stack: circular return-address LIFO; a push when full overwrites the oldest entry
module mc14500_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, top;
  // cnt keeps counting past DEPTH so pops after an overflow replay the wrapped entries
  logic [CW-1:0]    cnt;

  always_comb begin
    top   = wp == '0 ? AW'(DEPTH - 1) : wp - 1'b1;
    dout  = mem[top];
    full  = cnt >= CW'(DEPTH);
    empty = cnt == '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      cnt <= '0;
    end else if (push) begin
      wp  <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
      cnt <= cnt + CW'(cnt != '1);
    end else if (pop && !empty) begin
      wp  <= top;
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end
endmodule

// File: rtl/mc14500_icu.sv
// mc14500_icu: parametrised single-bit industrial control unit with absolute JMP, return stack and clock enable
module mc14500_icu
  import mc14500_pkg::*;
#(
  parameter int PC_W        = 12,
  parameter int NUM_IN      = 8,
  parameter int NUM_OUT     = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  output logic [PC_W-1:0]    pc_o,
  input  logic [7:0]         instr_i,
  input  logic [NUM_IN-1:0]  in_i,
  output logic [NUM_OUT-1:0] out_o,
  output logic               rr_o,
  output logic               ien_o,
  output logic               oen_o,
  output logic               flag0_o,
  output logic               flagf_o,
  output logic               jmp_o,
  output logic               rtn_o,
  output logic               stk_ovf_o,
  output logic               stk_unf_o
);
  localparam int EW = ext_words(PC_W);
  localparam int XW = 8 * EW;
  localparam int CW = EW > 1 ? $clog2(EW) : 1;

  state_t             state;
  logic [3:0]         op, imm, imm_q;
  logic [15:0]        in_pad;
  logic               raw, d, exec, st_val, we, rr_n, skip, last, push, pop, full, empty;
  logic [NUM_OUT-1:0] mask, out_n;
  logic [XW-1:0]      ext, ext_n;
  logic [CW-1:0]      ext_cnt;
  logic [PC_W-1:0]    pc_inc, stk_top;
  logic               flag0_q, flagf_q, jmp_q, rtn_q;

  always_comb begin
    op     = instr_i[3:0];
    imm    = instr_i[7:4];
    in_pad = 16'(in_i);
    raw    = in_pad[imm];
    d      = raw & ien_o;
    mask   = NUM_OUT'(16'h1 << imm);
    exec   = state == ST_EXEC && !skip;
    st_val = op == OP_STO ? rr_o : ~rr_o;
    we     = exec && oen_o && (op == OP_STO || op == OP_STOC);
    out_n  = we ? (st_val ? out_o | mask : out_o & ~mask) : out_o;
    ext_n  = XW'({instr_i, ext} >> 8);
    last   = state == ST_JEXT && ext_cnt == CW'(EW - 1);
    push   = ce && last;
    pop    = ce && exec && op == OP_RTN && !empty;
    pc_inc = pc_o + 1'b1;
    rr_n   = rr_o;
    case (op)
      OP_LD:   rr_n = d;
      OP_LDC:  rr_n = ~d;
      OP_AND:  rr_n = rr_o & d;
      OP_ANDC: rr_n = rr_o & ~d;
      OP_OR:   rr_n = rr_o | d;
      OP_ORC:  rr_n = rr_o | ~d;
      OP_XNOR: rr_n = ~(rr_o ^ d);
      default: rr_n = rr_o;
    endcase
  end

  mc14500_stack #(.WIDTH(PC_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EXEC;
      pc_o      <= '0;
      rr_o      <= 1'b0;
      ien_o     <= 1'b0;
      oen_o     <= 1'b0;
      out_o     <= '0;
      skip      <= 1'b0;
      imm_q     <= '0;
      ext       <= '0;
      ext_cnt   <= '0;
      stk_ovf_o <= 1'b0;
      stk_unf_o <= 1'b0;
      flag0_q   <= 1'b0;
      flagf_q   <= 1'b0;
      jmp_q     <= 1'b0;
      rtn_q     <= 1'b0;
    end else begin
      {flag0_q, flagf_q, jmp_q, rtn_q} <= '0;
      if (ce) begin
        if (state == ST_JEXT) begin
          ext     <= ext_n;
          ext_cnt <= ext_cnt + 1'b1;
          pc_o    <= last ? {ext_n, imm_q} : pc_inc;
          if (last) begin
            state     <= ST_EXEC;
            jmp_q     <= 1'b1;
            stk_ovf_o <= stk_ovf_o | full;
          end
        end else if (skip) begin
          // a discarded JMP also steps over its extension words
          skip <= 1'b0;
          pc_o <= op == OP_JMP ? pc_o + PC_W'(1 + EW) : pc_inc;
        end else begin
          rr_o  <= rr_n;
          out_o <= out_n;
          pc_o  <= pc_inc;
          case (op)
            OP_NOPO: flag0_q <= 1'b1;
            OP_NOPF: flagf_q <= 1'b1;
            OP_IEN:  ien_o <= raw;
            OP_OEN:  oen_o <= raw;
            OP_SKZ:  skip <= skip | ~rr_o;
            OP_JMP: begin
              imm_q   <= imm;
              ext_cnt <= '0;
              state   <= ST_JEXT;
            end
            OP_RTN: begin
              if (!empty) begin
                pc_o  <= stk_top;
                skip  <= 1'b1;
                rtn_q <= 1'b1;
              end else begin
                stk_unf_o <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign flag0_o = flag0_q & ce;
  assign flagf_o = flagf_q & ce;
  assign jmp_o   = jmp_q & ce;
  assign rtn_o   = rtn_q & ce;
endmodule

// File: tb/tb_mc14500_icu.sv
// tb_mc14500_icu: scoreboard bench; each expected {pc_o, jmp_o, rtn_o} is queued and checked one cycle at a time
module tb_mc14500_icu;
  logic        clk = 1'b0, rst_n = 1'b0, ce = 1'b1;
  logic [11:0] pc_o;
  logic [7:0]  instr_i, in_i = 8'h00, out_o;
  logic        rr_o, ien_o, oen_o, flag0_o, flagf_o, jmp_o, rtn_o, stk_ovf_o, stk_unf_o;
  logic [7:0]  rom [0:4095];
  int          vectors = 0, miscompares = 0;

  typedef struct packed {logic [11:0] pc; logic jmp; logic rtn;} exp_t;
  exp_t sb[$];

  assign instr_i = rom[pc_o];

  mc14500_icu #(.PC_W(12), .NUM_IN(8), .NUM_OUT(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .pc_o(pc_o), .instr_i(instr_i), .in_i(in_i),
    .out_o(out_o), .rr_o(rr_o), .ien_o(ien_o), .oen_o(oen_o), .flag0_o(flag0_o),
    .flagf_o(flagf_o), .jmp_o(jmp_o), .rtn_o(rtn_o), .stk_ovf_o(stk_ovf_o), .stk_unf_o(stk_unf_o)
  );

  always #5 clk = ~clk;

  function automatic void exp_pc(input logic [11:0] pc, input logic j, input logic r);
    sb.push_back({pc, j, r});
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    ce    = 1'b1;
    in_i  = 8'h00;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    in_i = 8'hFF;
    rom[0] = 8'h06; rom[1] = 8'h0A; rom[2] = 8'h0B; rom[3] = 8'h08;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (out_o !== 8'h01) begin miscompares++; $display("FAIL reset_pre_out: got %h want 01", out_o); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (pc_o !== 12'h000) begin miscompares++; $display("FAIL reset_pc: got %h want 000", pc_o); end
    vectors++;
    if (out_o !== 8'h00) begin miscompares++; $display("FAIL reset_out: got %h want 00", out_o); end
    vectors++;
    if ({rr_o, ien_o, oen_o, flag0_o, flagf_o, jmp_o, rtn_o, stk_ovf_o, stk_unf_o} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 000000000",
               {rr_o, ien_o, oen_o, flag0_o, flagf_o, jmp_o, rtn_o, stk_ovf_o, stk_unf_o});
    end
  endtask

  task automatic test_logic();
    exp_t e;
    do_reset();
    in_i = 8'hA5;
    rom[0] = 8'h06; rom[1] = 8'h0A; rom[2] = 8'h0B; rom[3] = 8'h21;
    rom[4] = 8'h03; rom[5] = 8'h38; rom[6] = 8'h12; rom[7] = 8'h48;
    for (int a = 1; a <= 8; a++) exp_pc(12'(a), 1'b0, 1'b0);
    rst_n = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({pc_o, jmp_o, rtn_o} !== e) begin
        miscompares++;
        $display("FAIL logic_trace: pc/jmp/rtn %h/%b/%b want %h/%b/%b", pc_o, jmp_o, rtn_o, e.pc, e.jmp, e.rtn);
      end
    end
    vectors++;
    if (out_o !== 8'h18) begin miscompares++; $display("FAIL logic_out: got %h want 18", out_o); end
    vectors++;
    if ({rr_o, ien_o, oen_o} !== 3'b111) begin miscompares++; $display("FAIL logic_regs: got %b want 111", {rr_o, ien_o, oen_o}); end
    @(posedge clk); #1;
    vectors++;
    if ({flag0_o, flagf_o} !== 2'b10) begin miscompares++; $display("FAIL logic_nopo: got %b want 10", {flag0_o, flagf_o}); end
  endtask

  task automatic test_oen_gating();
    exp_t e;
    do_reset();
    in_i = 8'hA5;
    rom[0] = 8'h1B; rom[1] = 8'h02; rom[2] = 8'h58; rom[3] = 8'h0A;
    rom[4] = 8'h0B; rom[5] = 8'h98; rom[6] = 8'h91; rom[7] = 8'h0F;
    for (int a = 1; a <= 8; a++) exp_pc(12'(a), 1'b0, 1'b0);
    rst_n = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({pc_o, jmp_o, rtn_o} !== e) begin
        miscompares++;
        $display("FAIL oen_trace: pc/jmp/rtn %h/%b/%b want %h/%b/%b", pc_o, jmp_o, rtn_o, e.pc, e.jmp, e.rtn);
      end
    end
    vectors++;
    if (out_o !== 8'h00) begin miscompares++; $display("FAIL oen_out: got %h want 00", out_o); end
    vectors++;
    if ({rr_o, oen_o, flagf_o, flag0_o} !== 4'b0110) begin
      miscompares++;
      $display("FAIL oen_regs: rr/oen/flagf/flag0 got %b want 0110", {rr_o, oen_o, flagf_o, flag0_o});
    end
  endtask

  task automatic test_jmp_rtn();
    exp_t e;
    do_reset();
    rom[12'h010] = 8'h4C; rom[12'h011] = 8'h23; rom[12'h012] = 8'h0F; rom[12'h234] = 8'h0D;
    for (int a = 1; a <= 12'h011; a++) exp_pc(12'(a), 1'b0, 1'b0);
    exp_pc(12'h234, 1'b1, 1'b0);
    exp_pc(12'h012, 1'b0, 1'b1);
    exp_pc(12'h013, 1'b0, 1'b0);
    rst_n = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({pc_o, jmp_o, rtn_o} !== e) begin
        miscompares++;
        $display("FAIL jmp_rtn_trace: pc/jmp/rtn %h/%b/%b want %h/%b/%b", pc_o, jmp_o, rtn_o, e.pc, e.jmp, e.rtn);
      end
    end
    vectors++;
    if ({flagf_o, stk_unf_o, stk_ovf_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL jmp_rtn_skip: flagf/unf/ovf got %b want 000", {flagf_o, stk_unf_o, stk_ovf_o});
    end
  endtask

  task automatic test_skz_jmp();
    exp_t e;
    do_reset();
    rom[12'h020] = 8'h0E; rom[12'h021] = 8'h4C; rom[12'h022] = 8'h23; rom[12'h023] = 8'h0D;
    for (int a = 1; a <= 12'h021; a++) exp_pc(12'(a), 1'b0, 1'b0);
    exp_pc(12'h023, 1'b0, 1'b0);
    exp_pc(12'h024, 1'b0, 1'b0);
    rst_n = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({pc_o, jmp_o, rtn_o} !== e) begin
        miscompares++;
        $display("FAIL skz_trace: pc/jmp/rtn %h/%b/%b want %h/%b/%b", pc_o, jmp_o, rtn_o, e.pc, e.jmp, e.rtn);
      end
    end
    vectors++;
    if (stk_unf_o !== 1'b1) begin miscompares++; $display("FAIL skz_stack_empty: unf got %b want 1", stk_unf_o); end
  endtask

  task automatic test_underflow();
    exp_t e;
    do_reset();
    rom[0] = 8'h0D;
    exp_pc(12'h001, 1'b0, 1'b0);
    rst_n = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({pc_o, jmp_o, rtn_o} !== e) begin
        miscompares++;
        $display("FAIL unf_trace: pc/jmp/rtn %h/%b/%b want %h/%b/%b", pc_o, jmp_o, rtn_o, e.pc, e.jmp, e.rtn);
      end
    end
    vectors++;
    if ({stk_unf_o, flag0_o} !== 2'b10) begin miscompares++; $display("FAIL unf_flags: unf/flag0 got %b want 10", {stk_unf_o, flag0_o}); end
  endtask

  task automatic test_stack();
    exp_t e;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      rom[12'(k * 256)]     = 8'h0C;
      rom[12'(k * 256 + 1)] = 8'(k * 16 + 16);
      if (k > 0) rom[12'(k * 256 + 3)] = 8'h0D;
    end
    rom[12'h500] = 8'h0D;
    exp_pc(12'h001, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      exp_pc(12'(k * 256), 1'b1, 1'b0);
      if (k < 5) exp_pc(12'(k * 256 + 1), 1'b0, 1'b0);
    end
    for (int k = 4; k >= 1; k--) begin
      exp_pc(12'(k * 256 + 2), 1'b0, 1'b1);
      exp_pc(12'(k * 256 + 3), 1'b0, 1'b0);
    end
    exp_pc(12'h402, 1'b0, 1'b1);
    exp_pc(12'h403, 1'b0, 1'b0);
    rst_n = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({pc_o, jmp_o, rtn_o} !== e) begin
        miscompares++;
        $display("FAIL stack_trace: pc/jmp/rtn %h/%b/%b want %h/%b/%b", pc_o, jmp_o, rtn_o, e.pc, e.jmp, e.rtn);
      end
    end
    vectors++;
    if ({stk_ovf_o, stk_unf_o} !== 2'b10) begin miscompares++; $display("FAIL stack_ovf: ovf/unf got %b want 10", {stk_ovf_o, stk_unf_o}); end
    @(posedge clk); #1;
    vectors++;
    if ({pc_o, stk_unf_o} !== {12'h404, 1'b1}) begin
      miscompares++;
      $display("FAIL stack_drained: pc/unf got %h/%b want 404/1", pc_o, stk_unf_o);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    do_reset();
    rom[0] = 8'h5C; rom[1] = 8'h67;
    rst_n = 1'b1;
    for (int ph = 0; ph < 3; ph++) begin
      ce = ph != 1;
      if (ph == 0) exp_pc(12'h001, 1'b0, 1'b0);
      if (ph == 1) repeat (3) exp_pc(12'h001, 1'b0, 1'b0);
      if (ph == 2) exp_pc(12'h675, 1'b1, 1'b0);
      while (sb.size() > 0) begin
        @(posedge clk); #1;
        e = sb.pop_front();
        vectors++;
        if ({pc_o, jmp_o, rtn_o} !== e) begin
          miscompares++;
          $display("FAIL stall_trace: pc/jmp/rtn %h/%b/%b want %h/%b/%b", pc_o, jmp_o, rtn_o, e.pc, e.jmp, e.rtn);
        end
      end
    end
    ce = 1'b0;
    #1;
    vectors++;
    if (jmp_o !== 1'b0) begin miscompares++; $display("FAIL stall_pulse_gate: jmp_o got %b want 0", jmp_o); end
    ce = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({pc_o, jmp_o} !== {12'h676, 1'b0}) begin
      miscompares++;
      $display("FAIL stall_resume: pc/jmp got %h/%b want 676/0", pc_o, jmp_o);
    end
  endtask

  task automatic test_reset_jext();
    exp_t e;
    do_reset();
    rom[0] = 8'h5C; rom[1] = 8'h67;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (pc_o !== 12'h001) begin miscompares++; $display("FAIL rst_jext_enter: pc got %h want 001", pc_o); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({pc_o, jmp_o} !== 13'h0) begin miscompares++; $display("FAIL rst_jext_async: pc/jmp got %h/%b want 000/0", pc_o, jmp_o); end
    @(posedge clk); #1;
    rom[0] = 8'h0D;
    exp_pc(12'h001, 1'b0, 1'b0);
    rst_n = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({pc_o, jmp_o, rtn_o} !== e) begin
        miscompares++;
        $display("FAIL rst_jext_trace: pc/jmp/rtn %h/%b/%b want %h/%b/%b", pc_o, jmp_o, rtn_o, e.pc, e.jmp, e.rtn);
      end
    end
    vectors++;
    if (stk_unf_o !== 1'b1) begin miscompares++; $display("FAIL rst_jext_no_push: unf got %b want 1", stk_unf_o); end
  endtask

  initial begin
    test_reset();
    test_logic();
    test_oen_gating();
    test_jmp_rtn();
    test_skz_jmp();
    test_underflow();
    test_stack();
    test_stall();
    test_reset_jext();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
